mp8_control_unit: RTL

- Multicycle fetch/decode/execute sequencer for the 8-bit microprocessor datapath (accumulator, ALU, data memory, instruction memory).
- Owns PC and IR. Drives every datapath control strobe.
- Started by the same `start` level the top-level bench raises after time 0.
- Instruction: opcode = ir[7:4], operand = ir[3:0] (4-bit address or immediate).

---
 rtl/mp8_control_unit.sv | 134 +++++++++++++
 1 files changed

// File: rtl/mp8_control_unit.sv
// Multicycle fetch/decode/execute sequencer for the 8-bit accumulator datapath.
// Owns PC and IR; every datapath strobe is decoded from the state and IR registers.
module mp8_control_unit #(
  parameter int PC_W = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [7:0]      i_instr,
  input  logic            i_zero_flag,
  output logic [PC_W-1:0] o_pc,
  output logic [7:0]      o_ir,
  output logic            o_imem_rd,
  output logic [3:0]      o_mem_addr,
  output logic            o_mem_rd,
  output logic            o_mem_we,
  output logic [2:0]      o_alu_op,
  output logic            o_acc_we,
  output logic            o_illegal_op,
  output logic            o_halted,
  output logic [2:0]      o_state
);

  // state | meaning: IDLE wait start, FETCH ir<=instr, DECODE pc+1, EXEC act on opcode, WB acc load, HALT stop
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [PC_W-1:0] r_pc, w_pc_nxt;
  logic [7:0]      r_ir, w_ir_nxt;
  logic [3:0]      w_opcode;
  logic [PC_W-1:0] w_target;
  logic [2:0]      w_alu_mem;

  assign w_opcode = r_ir[7:4];
  assign w_target = PC_W'(r_ir[3:0]);

  // ALU select for memory-operand instructions; shared by EXEC and WB so it holds across both
  always_comb begin
    w_alu_mem = 3'b000;
    case (w_opcode)
      4'h3:    w_alu_mem = 3'b001;
      4'h4:    w_alu_mem = 3'b010;
      4'h5:    w_alu_mem = 3'b011;
      4'h6:    w_alu_mem = 3'b100;
      default: w_alu_mem = 3'b000;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_ir    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ir    <= w_ir_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_ir_nxt     = r_ir;
    o_imem_rd    = 1'b0;
    o_mem_addr   = 4'h0;
    o_mem_rd     = 1'b0;
    o_mem_we     = 1'b0;
    o_alu_op     = 3'b000;
    o_acc_we     = 1'b0;
    o_illegal_op = 1'b0;
    o_halted     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        o_imem_rd   = 1'b1;
        w_ir_nxt    = i_instr;
        w_state_nxt = S_DECODE;
      end
      S_DECODE: begin
        w_pc_nxt    = r_pc + PC_W'(1);
        w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        o_mem_addr  = r_ir[3:0];
        w_state_nxt = S_FETCH;
        case (w_opcode)
          4'h0: ;
          4'h1, 4'h3, 4'h4, 4'h5, 4'h6: begin
            o_mem_rd    = 1'b1;
            o_alu_op    = w_alu_mem;
            w_state_nxt = S_WB;
          end
          4'h2: o_mem_we = 1'b1;
          4'h7: begin
            o_alu_op = 3'b101;
            o_acc_we = 1'b1;
          end
          4'h8: w_pc_nxt = w_target;
          4'h9: begin
            if (i_zero_flag) w_pc_nxt = w_target;
          end
          4'hF: w_state_nxt = S_HALT;
          default: o_illegal_op = 1'b1;
        endcase
      end
      S_WB: begin
        o_mem_addr  = r_ir[3:0];
        o_mem_rd    = 1'b1;
        o_alu_op    = w_alu_mem;
        o_acc_we    = 1'b1;
        w_state_nxt = S_FETCH;
      end
      S_HALT: begin
        o_halted = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_pc    = r_pc;
  assign o_ir    = r_ir;
  assign o_state = r_state;

endmodule
